seg7_readback_decoder: RTL and testbench

//  Receive side of the 7-segment display link. Samples the seven active-low segment lines
//  (leda..ledg) driven toward the display, filters transients, and converts each stable glyph

---
 rtl/seg7_readback_decoder.sv | 179 +++++++++++++++++
 tb/tb_seg7_readback_decoder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_readback_decoder.sv
// Receive-side decoder for the 7-segment display link.
// Synchronizes the active-low segment lines and waits for a glyph to hold
// steady for STABLE_CYCLES samples. Each qualified glyph is converted back
// to its digit value and offered once on a valid/ready output.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | display blank, nothing under qualification
// SETTLE | candidate glyph seen, counting consecutive identical samples
// HOLD   | candidate already reported, waiting for the pattern to change
module seg7_readback_decoder #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       leda,
   input  logic       ledb,
   input  logic       ledc,
   input  logic       ledd,
   input  logic       lede,
   input  logic       ledf,
   input  logic       ledg,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [5:0] out_value,
   output logic       out_err,
   output logic       overrun
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   logic [6:0]    sync_q [SYNC_STAGES];
   logic [6:0]    pat;
   state_t        state_q, state_d;
   logic [6:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic          restart;
   logic          emit;
   logic [6:0]    emit_pat;
   logic [6:0]    emit_dec;
   logic          out_valid_q, out_valid_d;
   logic [5:0]    out_value_q, out_value_d;
   logic          out_err_q, out_err_d;
   logic          overrun_q, overrun_d;

   // Glyph to {err, value}; unknown non-blank patterns report 6'h3F with err.
   function automatic logic [6:0] decode_glyph(input logic [6:0] p);
      logic [6:0] r;
      case (p)
         7'b1111110: r = {1'b0, 6'd0};
         7'b0110000: r = {1'b0, 6'd1};
         7'b1101101: r = {1'b0, 6'd2};
         7'b1111001: r = {1'b0, 6'd3};
         7'b0110011: r = {1'b0, 6'd4};
         7'b1011011: r = {1'b0, 6'd5};
         7'b1011111: r = {1'b0, 6'd6};
         7'b1110000: r = {1'b0, 6'd7};
         7'b1111111: r = {1'b0, 6'd8};
         7'b1111011: r = {1'b0, 6'd9};
         default:    r = {1'b1, 6'h3F};
      endcase
      return r;
   endfunction

   // Synchronizer chain on the raw pins; resets to all segments dark.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 7'h7F;
      end else begin
         sync_q[0] <= {leda, ledb, ledc, ledd, lede, ledf, ledg};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign pat     = ~sync_q[SYNC_STAGES-1];
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   // Qualification FSM: next state, candidate, stability counter and emit request.
   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      restart  = 1'b0;
      emit     = 1'b0;
      emit_pat = cand_q;
      case (state_q)
         ST_IDLE: restart = 1'b1;
         ST_SETTLE: begin
            if (pat == 7'd0) begin
               state_d = ST_IDLE;
            end else if (pat != cand_q) begin
               restart = 1'b1;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_MAX) begin
                  emit    = 1'b1;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (pat != cand_q) restart = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      // A changed pattern is handled exactly as if it arrived in IDLE.
      if (restart) begin
         if (pat == 7'd0) begin
            state_d = ST_IDLE;
         end else begin
            cand_d   = pat;
            cnt_d    = CW'(1);
            emit_pat = pat;
            if (STABLE_CYCLES == 1) begin
               emit    = 1'b1;
               state_d = ST_HOLD;
            end else begin
               state_d = ST_SETTLE;
            end
         end
      end
   end

   assign emit_dec = decode_glyph(emit_pat);

   // Output slot: transfer on valid&&ready, load on emit when the slot frees, else flag overrun.
   always_comb begin
      out_valid_d = out_valid_q && !out_ready;
      out_value_d = out_value_q;
      out_err_d   = out_err_q;
      overrun_d   = overrun_q;
      if (emit) begin
         if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            out_value_d = emit_dec[5:0];
            out_err_d   = emit_dec[6];
         end else begin
            out_valid_d = 1'b1;
            overrun_d   = 1'b1;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cand_q      <= 7'd0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_value_q <= 6'd0;
         out_err_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_value_q <= out_value_d;
         out_err_q   <= out_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_value = out_value_q;
   assign out_err   = out_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Testbench for seg7_readback_decoder: directed scenarios plus random glyph
// streams, checked against a run-length reference model of the link.
module tb_seg7_readback_decoder;

   localparam int SYNC   = 2;
   localparam int STABLE = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       leda, ledb, ledc, ledd, lede, ledf, ledg;
   logic       out_ready;
   logic       out_valid;
   logic [5:0] out_value;
   logic       out_err;
   logic       overrun;
   logic [8:0] dut_vec;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [6:0] glyph_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                  7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

   // reference model state
   logic [6:0] m_hist [SYNC];
   logic [6:0] m_last;
   int         m_run;
   logic       m_valid;
   logic [5:0] m_value;
   logic       m_err;
   logic       m_ov;

   seg7_readback_decoder #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE)) dut (
      .clk(clk), .rst(rst),
      .leda(leda), .ledb(ledb), .ledc(ledc), .ledd(ledd),
      .lede(lede), .ledf(ledf), .ledg(ledg),
      .out_ready(out_ready), .out_valid(out_valid), .out_value(out_value),
      .out_err(out_err), .overrun(overrun)
   );

   assign dut_vec = {out_valid, out_value, out_err, overrun};

   always #5 clk = ~clk;

   task automatic set_p(input logic [6:0] p);
      {leda, ledb, ledc, ledd, lede, ledf, ledg} = ~p;
   endtask

   function automatic logic [6:0] ref_decode(input logic [6:0] p);
      logic [6:0] r;
      r = {1'b1, 6'h3F};
      for (int d = 0; d < 10; d++) if (glyph_tab[d] == p) r = {1'b0, 6'(d)};
      return r;
   endfunction

   function automatic logic [8:0] model_vec();
      return {m_valid, m_value, m_err, m_ov};
   endfunction

   // Model: a non-blank glyph is reported when its run of identical samples
   // (seen SYNC edges after the pins) reaches exactly STABLE.
   task automatic model_step();
      logic [6:0] seen;
      logic [6:0] dec;
      logic       emit;
      if (rst) begin
         for (int i = 0; i < SYNC; i++) m_hist[i] = 7'd0;
         m_last = 7'd0; m_run = 0;
         m_valid = 1'b0; m_value = 6'd0; m_err = 1'b0; m_ov = 1'b0;
      end else begin
         seen = m_hist[SYNC-1];
         for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = ~{leda, ledb, ledc, ledd, lede, ledf, ledg};
         if (seen == 7'd0) begin
            m_run = 0;
         end else if (seen == m_last) begin
            if (m_run <= STABLE) m_run++;
         end else begin
            m_run = 1;
         end
         m_last = seen;
         emit = (seen != 7'd0) && (m_run == STABLE);
         dec = ref_decode(seen);
         if (emit) begin
            if (!m_valid || out_ready) begin
               m_valid = 1'b1; m_value = dec[5:0]; m_err = dec[6];
            end else begin
               m_ov = 1'b1;
            end
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
      end
   endtask

   always @(posedge clk) model_step();

   task automatic test_reset();
      rst = 1'b1; out_ready = 1'b0; set_p(7'd0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n_cmp++;
         if (c > 0 && dut_vec !== 9'd0) begin
            n_fail++; $display("FAIL reset_outputs cyc=%0d got=%h want=000", c, dut_vec);
         end
      end
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL reset_dark cyc=%0d got=%h want=%h", c, dut_vec, model_vec());
         end
      end
   endtask

   task automatic test_single_glyph();
      set_p(glyph_tab[3]); out_ready = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== (e == 6)) begin
            n_fail++; $display("FAIL single_valid edge=%0d got=%b want=%b", e, out_valid, (e == 6));
         end
         if (e == 6) begin
            n_cmp++;
            if ({out_err, out_value} !== {1'b0, 6'd3}) begin
               n_fail++; $display("FAIL single_value got=%h/%b want=3/0", out_value, out_err);
            end
         end
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL single_model edge=%0d got=%h want=%h", e, dut_vec, model_vec());
         end
      end
   endtask

   task automatic test_overrun();
      set_p(7'd0); out_ready = 1'b1;
      repeat (4) @(negedge clk);
      out_ready = 1'b0; set_p(glyph_tab[5]);
      repeat (10) @(negedge clk);
      n_cmp++;
      if (dut_vec !== {1'b1, 6'd5, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL overrun_first got=%h want=%h", dut_vec, {1'b1, 6'd5, 1'b0, 1'b0});
      end
      set_p(glyph_tab[7]);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({out_valid, out_value, out_err} !== {1'b1, 6'd5, 1'b0}) begin
            n_fail++; $display("FAIL overrun_hold cyc=%0d got=%h want=5", c, out_value);
         end
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL overrun_model cyc=%0d got=%h want=%h", c, dut_vec, model_vec());
         end
      end
      n_cmp++;
      if (overrun !== 1'b1) begin
         n_fail++; $display("FAIL overrun_flag got=%b want=1", overrun);
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({out_valid, overrun} !== 2'b01) begin
         n_fail++; $display("FAIL overrun_drain got=%b%b want=01", out_valid, overrun);
      end
   endtask

   task automatic test_glitch();
      int hits;
      hits = 0;
      set_p(7'd0); out_ready = 1'b1;
      repeat (4) @(negedge clk);
      for (int e = 1; e <= 20; e++) begin
         set_p((e == 3 || e == 4) ? glyph_tab[7] : glyph_tab[1]);
         @(negedge clk);
         if (out_valid) hits++;
         n_cmp++;
         if (out_valid !== (e == 10)) begin
            n_fail++; $display("FAIL glitch_valid edge=%0d got=%b want=%b", e, out_valid, (e == 10));
         end
         if (out_valid) begin
            n_cmp++;
            if (out_value !== 6'd1) begin
               n_fail++; $display("FAIL glitch_value got=%0d want=1", out_value);
            end
         end
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL glitch_model edge=%0d got=%h want=%h", e, dut_vec, model_vec());
         end
      end
      n_cmp++;
      if (hits != 1) begin
         n_fail++; $display("FAIL glitch_count got=%0d want=1", hits);
      end
   endtask

   task automatic test_illegal();
      set_p(7'd0); out_ready = 1'b1;
      repeat (4) @(negedge clk);
      set_p(7'b1000001);
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== (e == 6)) begin
            n_fail++; $display("FAIL illegal_valid edge=%0d got=%b want=%b", e, out_valid, (e == 6));
         end
         if (e == 6) begin
            n_cmp++;
            if ({out_err, out_value} !== {1'b1, 6'h3F}) begin
               n_fail++; $display("FAIL illegal_value got=%h/%b want=3f/1", out_value, out_err);
            end
         end
      end
      set_p(7'd0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL blank_valid cyc=%0d got=%b want=0", c, out_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      set_p(7'd0); out_ready = 1'b0;
      repeat (4) @(negedge clk);
      set_p(glyph_tab[2]);
      repeat (8) @(negedge clk);
      n_cmp++;
      if ({out_valid, out_value} !== {1'b1, 6'd2}) begin
         n_fail++; $display("FAIL rstmid_pending got=%b/%0d want=1/2", out_valid, out_value);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (dut_vec !== 9'd0) begin
         n_fail++; $display("FAIL rstmid_clear got=%h want=000", dut_vec);
      end
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== (e >= 6)) begin
            n_fail++; $display("FAIL rstmid_requal edge=%0d got=%b want=%b", e, out_valid, (e >= 6));
         end
      end
      n_cmp++;
      if (out_value !== 6'd2) begin
         n_fail++; $display("FAIL rstmid_value got=%0d want=2", out_value);
      end
      out_ready = 1'b1;
      @(negedge clk);
      set_p(7'd0);
      repeat (4) @(negedge clk);
      set_p(glyph_tab[4]);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (dut_vec !== 9'd0) begin
         n_fail++; $display("FAIL rstsettle_clear got=%h want=000", dut_vec);
      end
      for (int e = 1; e <= 9; e++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== (e == 6)) begin
            n_fail++; $display("FAIL rstsettle_valid edge=%0d got=%b want=%b", e, out_valid, (e == 6));
         end
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL rstsettle_model edge=%0d got=%h want=%h", e, dut_vec, model_vec());
         end
      end
   endtask

   task automatic test_sweep();
      logic [5:0] got [$];
      set_p(7'd0); out_ready = 1'b1;
      repeat (4) @(negedge clk);
      for (int d = 0; d < 11; d++) begin
         if (d < 10) set_p(glyph_tab[d]); else set_p(7'd0);
         for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (out_valid) got.push_back(out_value);
            n_cmp++;
            if (dut_vec !== model_vec()) begin
               n_fail++; $display("FAIL sweep_model d=%0d cyc=%0d got=%h want=%h", d, c, dut_vec, model_vec());
            end
         end
      end
      n_cmp++;
      if (got.size() != 10) begin
         n_fail++; $display("FAIL sweep_count got=%0d want=10", got.size());
      end
      for (int i = 0; i < got.size() && i < 10; i++) begin
         n_cmp++;
         if (got[i] !== 6'(i)) begin
            n_fail++; $display("FAIL sweep_order idx=%0d got=%0d want=%0d", i, got[i], i);
         end
      end
   endtask

   task automatic test_random();
      int hold;
      int sel;
      logic [6:0] p;
      hold = 0;
      p = 7'd0;
      for (int c = 0; c < 600; c++) begin
         if (hold == 0) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 60)      p = glyph_tab[$urandom_range(0, 9)];
            else if (sel < 75) p = 7'd0;
            else               p = 7'($urandom);
            hold = int'($urandom_range(1, 8));
            set_p(p);
         end
         hold--;
         out_ready = ($urandom_range(0, 99) < 65);
         rst = ($urandom_range(0, 99) < 2);
         @(negedge clk);
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL random_model cyc=%0d got=%h want=%h", c, dut_vec, model_vec());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      set_p(7'd0);
      test_reset();
      test_single_glyph();
      test_overrun();
      test_glitch();
      test_illegal();
      test_reset_mid();
      test_sweep();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
